// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one line-wide memory port between the I-cache and D-cache miss
//   ports. One transaction at a time, round-robin on simultaneous requests,
//   registered read line and a one-cycle completion pulse to the winner.
//
// Ports
//   clk, rst_n            : clock, async active-low reset
//   i_read/i_addr         : I-cache line read request (held until i_resp)
//   i_rdata/i_resp        : I-cache returned line / completion pulse
//   d_read/d_write/d_addr : D-cache read or writeback request (held until d_resp)
//   d_wdata               : D-cache writeback line
//   d_rdata/d_resp        : D-cache returned line / completion pulse
//   mem_read/mem_write    : memory strobes, held until mem_resp
//   mem_addr/mem_wdata    : address / writeback line latched at grant
//   mem_rdata/mem_resp    : memory read line / one-cycle completion
//   arb_busy              : high whenever the FSM is not IDLE
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              arb_busy
);

  typedef enum logic [1:0] {IDLE, SERV_I, SERV_D, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;   // 1: last grant went to D
  logic                wr_q, wr_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_resp_q, i_resp_d;
  logic                d_resp_q, d_resp_d;
  logic                arb_busy_q, arb_busy_d;
  logic                i_req, d_req;

  // All outputs are next-state decoded here and registered below, so the
  // strobes and address never see a combinational path from the inputs.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    wr_d        = wr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
    i_req       = i_read;
    d_req       = d_read | d_write;

    unique case (state_q)
      IDLE: begin
        // D wins when alone, or on a tie when I had the previous grant.
        if (d_req && (!i_req || !last_d_q)) begin
          state_d     = SERV_D;
          last_d_d    = 1'b1;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          wr_d        = d_write;        // read+write together is a write
          mem_read_d  = !d_write;
          mem_write_d = d_write;
        end else if (i_req) begin
          state_d     = SERV_I;
          last_d_d    = 1'b0;
          mem_addr_d  = i_addr;
          wr_d        = 1'b0;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end
      end
      SERV_I: begin
        if (mem_resp) begin
          i_rdata_d   = mem_rdata;
          i_resp_d    = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
        end
      end
      SERV_D: begin
        if (mem_resp) begin
          if (!wr_q) d_rdata_d = mem_rdata;
          d_resp_d    = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      wr_q        <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      arb_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      wr_q        <= wr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
      arb_busy_q  <= arb_busy_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;
  assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk, rst_n;
  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write, arb_busy;
  logic [AW-1:0] mem_addr;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .arb_busy(arb_busy)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit            d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } txn_t;

  txn_t gnt_q[$];
  txn_t rsp_q[$];
  logic [LW-1:0] i_m = '0;   // model of i_rdata
  logic [LW-1:0] d_m = '0;   // model of d_rdata

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    if (a == 32'h60) return {32{8'hA5}};
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic expect_txn(input bit d, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    txn_t e;
    e.d = d; e.wr = wr; e.addr = a; e.wdata = wd;
    e.rdata = wr ? '0 : line_of(a);
    gnt_q.push_back(e);
    rsp_q.push_back(e);
  endtask

  // Memory model: answers k = mem_dly cycles after the strobe first rises;
  // data bus carries junk outside the response cycle.
  int mem_dly = 1;
  initial begin
    int mcnt;
    mcnt = 0; mem_resp = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = {8{$urandom}};
      if (rst_n && (mem_read || mem_write)) begin
        mcnt++;
        if (mcnt == mem_dly) begin
          mem_resp  = 1'b1;
          mem_rdata = line_of(mem_addr);
        end
      end else mcnt = 0;
    end
  end

  // Scoreboard monitor: grant side pops gnt_q, response side pops rsp_q.
  initial begin
    bit   prev_str;
    txn_t cur, e;
    prev_str = 1'b0;
    cur = '{d: 1'b0, wr: 1'b0, addr: '0, wdata: '0, rdata: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) prev_str = 1'b0;
      else begin
        if ((mem_read || mem_write) && !prev_str) begin
          if (gnt_q.size() == 0) chk("unexp_grant", gnt_q.size(), 1);
          else begin
            cur = gnt_q.pop_front();
            chk("gnt_addr", mem_addr, cur.addr);
            chk("gnt_write", mem_write, cur.wr);
            chk("gnt_read", mem_read, !cur.wr);
            if (cur.d) chk("gnt_wdata", mem_wdata, cur.wdata);
          end
        end else if (mem_read || mem_write) begin
          chk("hold_addr", mem_addr, cur.addr);
          if (cur.d) chk("hold_wdata", mem_wdata, cur.wdata);
        end
        prev_str = mem_read || mem_write;
        if (i_resp || d_resp) begin
          chk("dual_resp", i_resp & d_resp, 0);
          chk("strobe_in_resp", mem_read | mem_write, 0);
          if (rsp_q.size() == 0) chk("unexp_resp", rsp_q.size(), 1);
          else begin
            e = rsp_q.pop_front();
            chk("resp_side", d_resp, e.d);
            if (d_resp && !e.wr) d_m = e.rdata;
            if (i_resp) i_m = e.rdata;
            chk("i_rdata", i_rdata, i_m);
            chk("d_rdata", d_rdata, d_m);
          end
        end
      end
    end
  end

  task automatic req_i(input logic [AW-1:0] a, input bit timed, input int k);
    int n; bit got;
    i_addr = a; i_read = 1'b1; n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      if (i_resp) got = 1'b1;
      else if (timed) chk("i_strobe", mem_read, 1);
    end
    i_read = 1'b0;
    chk("i_resp_seen", got, 1);
    if (timed) chk("i_latency", n, k + 1);
    @(negedge clk);
    if (timed) chk("i_idle_k2", arb_busy, 0);
  endtask

  task automatic req_d(input logic [AW-1:0] a, input bit rd, input bit wr,
                       input logic [LW-1:0] wd, input bit timed, input int k, input bit wiggle);
    int n; bit got;
    d_addr = a; d_wdata = wd; d_read = rd; d_write = wr; n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      if (d_resp) got = 1'b1;
      else if (timed) begin
        chk("d_mem_write", mem_write, wr);
        chk("d_mem_read", mem_read, !wr);
      end
      if (wiggle && n == 1) begin d_addr = ~a; d_wdata = ~wd; end
    end
    d_read = 1'b0; d_write = 1'b0;
    chk("d_resp_seen", got, 1);
    if (timed) chk("d_latency", n, k + 1);
    @(negedge clk);
    if (timed) chk("d_idle_k2", arb_busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_read"},  mem_read,  0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_i_rdata"},   i_rdata,   0);
    chk({tag, "_d_rdata"},   d_rdata,   0);
    chk({tag, "_i_resp"},    i_resp,    0);
    chk({tag, "_d_resp"},    d_resp,    0);
    chk({tag, "_arb_busy"},  arb_busy,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation hung");
  end

  initial begin
    rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Tie right after reset: D, I, D, I with immediate re-requests.
    mem_dly = 2;
    expect_txn(1, 0, 32'h200, {8{32'h200}});
    expect_txn(0, 0, 32'h080, '0);
    expect_txn(1, 0, 32'h240, {8{32'h240}});
    expect_txn(0, 0, 32'h0C0, '0);
    fork
      begin
        req_d(32'h200, 1, 0, {8{32'h200}}, 0, 0, 0);
        req_d(32'h240, 1, 0, {8{32'h240}}, 0, 0, 0);
      end
      begin
        req_i(32'h080, 0, 0);
        req_i(32'h0C0, 0, 0);
      end
    join
    repeat (2) @(negedge clk);

    // Single I read, 3-cycle memory.
    mem_dly = 3;
    expect_txn(0, 0, 32'h60, '0);
    req_i(32'h60, 1, 3);
    chk("i_rdata_a5", i_rdata, {32{8'hA5}});

    // D writeback, 1-cycle memory; d_rdata must not change.
    mem_dly = 1;
    expect_txn(1, 1, 32'h100, {8{32'h1234_5678}});
    req_d(32'h100, 0, 1, {8{32'h1234_5678}}, 1, 1, 0);

    // D read with address/data changing during service.
    mem_dly = 4;
    expect_txn(1, 0, 32'h300, {8{32'hDEAD_BEEF}});
    req_d(32'h300, 1, 0, {8{32'hDEAD_BEEF}}, 1, 4, 1);

    // Read and write together: treated as a write.
    mem_dly = 2;
    expect_txn(1, 1, 32'h340, {8{32'hCAFE_F00D}});
    req_d(32'h340, 1, 1, {8{32'hCAFE_F00D}}, 1, 2, 0);

    // Reset during SERV_I: outputs clear at once, no response afterwards.
    mem_dly = 6;
    expect_txn(0, 0, 32'h400, '0);
    i_addr = 32'h400; i_read = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    i_read = 1'b0;
    rsp_q.delete();
    i_m = '0; d_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_idle", arb_busy, 0);
    mem_dly = 2;
    expect_txn(0, 0, 32'h440, '0);
    req_i(32'h440, 1, 2);

    repeat (3) @(negedge clk);
    chk("gnt_q_left", gnt_q.size(), 0);
    chk("rsp_q_left", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
